// File: rtl/mul8s_share_arb_if.sv
// Operand request bus (NREQ streams) and tagged product response bus
// shared between the requesters, the consumer and mul8s_share_arb.
interface mul8s_share_arb_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [15:0]       rsp_prod;
  logic [IDW-1:0]    rsp_id;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_prod, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_prod, rsp_id
  );
endinterface

// File: rtl/mul8s_share_arb.sv
// Round-robin time-sharing of one 8x8 signed multiplier between NREQ operand
// streams; S1 registers operands in front of the multiplier, S2 the product.
module mul8s_share_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst,
  mul8s_share_arb_if.slave   bus,
  output logic [31:0]        op_count
);

  logic [IDW-1:0]    ptr_q, ptr_d;
  logic              s1_valid_q, s1_valid_d;
  logic [7:0]        s1_a_q, s1_a_d;
  logic [7:0]        s1_b_q, s1_b_d;
  logic [IDW-1:0]    s1_id_q, s1_id_d;
  logic              s2_valid_q, s2_valid_d;
  logic [15:0]       s2_prod_q, s2_prod_d;
  logic [IDW-1:0]    s2_id_q, s2_id_d;
  logic [31:0]       cnt_q, cnt_d;

  logic [IDW-1:0]    win;
  logic              found;
  logic              s2_load;
  logic              s1_free;
  logic              grant;
  logic              rsp_fire;
  logic signed [15:0] a_ext, b_ext;
  logic [15:0]       mul_o;

  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // Exact multiplier; an approximate mul8s variant with the same A/B/O
  // behaviour drops in here, fed only from S1 and captured only by S2.
  assign a_ext = {{8{s1_a_q[7]}}, s1_a_q};
  assign b_ext = {{8{s1_b_q[7]}}, s1_b_q};
  assign mul_o = a_ext * b_ext;

  assign s2_load  = s1_valid_q & (~s2_valid_q | bus.rsp_ready);
  assign s1_free  = ~s1_valid_q | s2_load;
  assign grant    = found & s1_free;
  assign rsp_fire = s2_valid_q & bus.rsp_ready;

  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && bus.req_valid[rr_idx(ptr_q, k)]) begin
        found = 1'b1;
        win   = rr_idx(ptr_q, k);
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (found) bus.req_ready[win] = s1_free;
  end

  always_comb begin
    ptr_d      = ptr_q;
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_id_d    = s1_id_q;
    s2_valid_d = s2_valid_q;
    s2_prod_d  = s2_prod_q;
    s2_id_d    = s2_id_q;
    cnt_d      = cnt_q + 32'(rsp_fire);

    if (s2_load) begin
      s2_valid_d = 1'b1;
      s2_prod_d  = mul_o;
      s2_id_d    = s1_id_q;
    end else if (rsp_fire) begin
      s2_valid_d = 1'b0;
    end

    if (grant) begin
      s1_valid_d = 1'b1;
      s1_a_d     = bus.req_a[8*int'(win) +: 8];
      s1_b_d     = bus.req_b[8*int'(win) +: 8];
      s1_id_d    = win;
      ptr_d      = rr_idx(win, 1);
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_prod_q  <= '0;
      s2_id_q    <= '0;
      cnt_q      <= '0;
    end else begin
      ptr_q      <= ptr_d;
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_prod_q  <= s2_prod_d;
      s2_id_q    <= s2_id_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.rsp_valid = s2_valid_q;
  assign bus.rsp_prod  = s2_prod_q;
  assign bus.rsp_id    = s2_id_q;
  assign op_count      = cnt_q;

endmodule

// File: tb/tb_mul8s_share_arb.sv
// Bench for mul8s_share_arb: a grant-order queue model checked every cycle,
// directed literal cases, and an all-pairs randomized sweep.
module tb_mul8s_share_arb;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] op_count;

  mul8s_share_arb_if #(.NREQ(NREQ), .IDW(IDW)) bus ();
  mul8s_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .op_count(op_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: responses leave in grant order; each one is visible from the
  // second edge after its grant; at most two operations in flight.
  typedef struct {
    int          id;
    logic [15:0] prod;
    int          g;
  } item_t;

  item_t           q[$];
  int              m_ptr, m_cnt, m_win;
  int              cyc = 0;
  bit              model_ok = 0;
  bit              m_free, m_rv;
  logic [NREQ-1:0] m_rdy;

  function automatic logic [15:0] smul(logic [7:0] a, logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[15:0];
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_ptr    = 0;
      m_cnt    = 0;
      model_ok = 1;
    end else if (model_ok) begin
      m_win = -1;
      for (int k = 0; k < NREQ; k++)
        if (m_win < 0 && bus.req_valid[(m_ptr + k) % NREQ]) m_win = (m_ptr + k) % NREQ;
      m_free = (q.size() < 2) || bus.rsp_ready;
      m_rdy  = '0;
      if (m_win >= 0 && m_free) m_rdy[m_win] = 1'b1;
      check("model_req_ready", 32'(bus.req_ready), 32'(m_rdy));
      m_rv = (q.size() > 0) && (q[0].g + 2 <= cyc);
      check("model_rsp_valid", 32'(bus.rsp_valid), 32'(m_rv));
      if (m_rv) begin
        check("model_rsp_prod", 32'(bus.rsp_prod), 32'(q[0].prod));
        check("model_rsp_id", 32'(bus.rsp_id), q[0].id);
      end
      check("model_op_count", op_count, m_cnt);
      if (m_rv && bus.rsp_ready) begin
        void'(q.pop_front());
        m_cnt++;
      end
      if (m_win >= 0 && m_free) begin
        q.push_back('{m_win, smul(bus.req_a[8*m_win +: 8], bus.req_b[8*m_win +: 8]), cyc});
        m_ptr = (m_win + 1) % NREQ;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(int i, logic [7:0] a, logic [7:0] b);
    bus.req_a[8*i +: 8] = a;
    bus.req_b[8*i +: 8] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic send(int i, logic [7:0] a, logic [7:0] b);
    logic got;
    got = 1'b0;
    set_op(i, a, b);
    bus.req_valid = NREQ'(1) << i;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      got = bus.req_ready[i];
      tick();
      if (got) break;
    end
    check("send_granted", 32'(got), 32'd1);
    bus.req_valid = '0;
  endtask

  task automatic expect_rsp(string name, logic [15:0] prod, int id);
    logic got;
    got = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        got = 1'b1;
        check({name, "_prod"}, 32'(bus.rsp_prod), 32'(prod));
        check({name, "_id"}, 32'(bus.rsp_id), id);
      end
      tick();
      if (got) break;
    end
    check({name, "_seen"}, 32'(got), 32'd1);
  endtask

  logic [NREQ-1:0] acc;
  int              n_acc;
  int              pair, done;
  bit              stall_ok;

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;

    // Reset state and single request (-128 * -128)
    bus.rsp_ready = 1'b1;
    set_op(0, 8'h80, 8'h80);
    bus.req_valid = 4'b0001;
    @(negedge clk);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_prod", 32'(bus.rsp_prod), 0);
    check("rst_op_count", op_count, 0);
    check("single_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    check("single_lat1_valid", 32'(bus.rsp_valid), 0);
    tick();
    @(negedge clk);
    check("single_valid", 32'(bus.rsp_valid), 1);
    check("single_prod", 32'(bus.rsp_prod), 32'h4000);
    check("single_id", 32'(bus.rsp_id), 0);
    check("single_cnt_before", op_count, 0);
    tick();
    @(negedge clk);
    check("single_cnt_after", op_count, 1);
    check("single_drained", 32'(bus.rsp_valid), 0);
    tick();

    // Sign corners on requester 2
    send(2, 8'h80, 8'h7f);  expect_rsp("corner_m128x127", 16'hC080, 2);
    send(2, 8'h7f, 8'h7f);  expect_rsp("corner_127x127", 16'h3F01, 2);
    send(2, 8'hff, 8'h01);  expect_rsp("corner_m1x1", 16'hFFFF, 2);
    @(negedge clk);
    check("corner_count", op_count, 4);
    tick();

    // Fairness: all requesters held valid from ptr = 0
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 8'(i + 3), 8'(8'hF0 + i));
    bus.rsp_ready = 1'b1;
    bus.req_valid = '1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      check("fair_grant", 32'(bus.req_ready), 32'(1) << (j % 4));
      if (j >= 2) check("fair_rsp_id", 32'(bus.rsp_id), (j - 2) % 4);
      tick();
    end
    bus.req_valid = '0;
    for (int j = 0; j < 4; j++) tick();

    // Backpressure on a requester-1 stream
    do_reset();
    n_acc    = 0;
    stall_ok = 1;
    set_op(1, 8'h11, 8'h22);
    bus.req_valid = 4'b0010;
    for (int j = 0; j < 12; j++) begin
      bus.rsp_ready = !(j >= 3 && j < 6);
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      if (j >= 3 && j < 6) begin
        check("bp_ready_low", 32'(bus.req_ready), 0);
        check("bp_rsp_held", 32'(bus.rsp_valid), 1);
      end
      tick();
      if (acc[1]) begin
        n_acc++;
        set_op(1, 8'($urandom), 8'($urandom));
      end
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    for (int j = 0; j < 4; j++) tick();
    @(negedge clk);
    check("bp_count", op_count, n_acc);
    check("bp_accepts", n_acc, 9);
    tick();

    // Reset with both stages full
    bus.rsp_ready = 1'b0;
    set_op(0, 8'h05, 8'h06);
    set_op(1, 8'h07, 8'h08);
    bus.req_valid = 4'b0011;
    tick(); tick();
    bus.req_valid = '0;
    @(negedge clk);
    check("full_rsp_valid", 32'(bus.rsp_valid), 1);
    check("full_ready", 32'(bus.req_ready), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_op(3, 8'h9c, 8'h03);
    bus.req_valid = 4'b1000;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("rstmid_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rstmid_op_count", op_count, 0);
    check("rstmid_rsp_id", 32'(bus.rsp_id), 0);
    check("rstmid_req3_ready", 32'(bus.req_ready), 32'h8);
    tick();
    bus.req_valid = '1;
    @(negedge clk);
    check("rstmid_ptr_wrap", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    expect_rsp("rstmid_req3", 16'hFED4, 3);
    for (int j = 0; j < 4; j++) tick();

    // All 65536 operand pairs, random requesters and random rsp_ready
    do_reset();
    pair = 0;
    done = 0;
    bus.req_valid = '0;
    for (int c = 0; c < 90000; c++) begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      if (bus.rsp_valid && bus.rsp_ready) done++;
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) bus.req_valid[i] = 1'b0;
        if (!bus.req_valid[i] && pair < 65536 && $urandom_range(3) != 0) begin
          set_op(i, pair[15:8], pair[7:0]);
          bus.req_valid[i] = 1'b1;
          pair++;
        end
      end
      bus.rsp_ready = ($urandom_range(31) != 0);
      if (pair == 65536 && done == 65536) break;
    end
    check("exh_issued", pair, 65536);
    check("exh_done", done, 65536);
    @(negedge clk);
    check("exh_op_count", op_count, 65536);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
